// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, the highest
// legal opcode and the FSM state type.
package alu_pkg;

    typedef enum logic [3:0] {
        PASS = 4'd0,
        ADD  = 4'd1,
        SUB  = 4'd2,
        SHL1 = 4'd3,
        SHL2 = 4'd4,
        SHR4 = 4'd5,
        INC  = 4'd6
    } alu_op_e;

    localparam logic [3:0] LAST_OP = INC;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        WAIT_D,
        CAPT,
        RESP
    } state_e;

    function automatic logic isLegalOp(input logic [3:0] op, input logic [3:0] lastOp);
        return op <= lastOp;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters and the arbiter.
interface alu_arbiter_if #(
    parameter int DWIDTH = 16
);

    logic              req0_valid;
    logic              req0_ready;
    logic [3:0]        req0_op;
    logic [DWIDTH-1:0] req0_a;
    logic [DWIDTH-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [3:0]        req1_op;
    logic [DWIDTH-1:0] req1_a;
    logic [DWIDTH-1:0] req1_b;

    logic              rsp0_valid;
    logic              rsp1_valid;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_data;
    logic              rsp_zero;
    logic              rsp_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_zero, rsp_err
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant; the requester not served last wins a tie.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       served_i,
    output logic [1:0] grant_o
);

    logic lastServed_q;

    // Reset to requester 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lastServed_q <= 1'b1;
        end else if (update_i) begin
            lastServed_q <= served_i;
        end
    end

    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = lastServed_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external registered ALU between two requesters; legal ops go
// through a fixed EXEC/WAIT_D/CAPT pipeline, illegal ops answer immediately.
module alu_arbiter #(
    parameter int         DWIDTH  = 16,
    parameter logic [3:0] LAST_OP = alu_pkg::LAST_OP
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    output logic [DWIDTH-1:0] alu_operand1,
    output logic [DWIDTH-1:0] alu_operand2,
    output logic [3:0]        alu_operation,
    input  logic [DWIDTH-1:0] alu_dout,
    input  logic              alu_z,
    output logic              busy
);

    import alu_pkg::*;

    state_e            state_q, state_d;
    logic              grantee_q, grantee_d;
    logic [3:0]        aluOp_q, aluOp_d;
    logic [DWIDTH-1:0] aluA_q, aluA_d;
    logic [DWIDTH-1:0] aluB_q, aluB_d;
    logic [DWIDTH-1:0] rspData_q, rspData_d;
    logic              rspZero_q, rspZero_d;
    logic              rspErr_q, rspErr_d;

    logic              idle;
    logic [1:0]        reqValid;
    logic [1:0]        grant;
    logic [1:0]        reqReady;
    logic              handshake;
    logic              hsSel;
    logic              arbUpdate;
    logic [3:0]        selOp;
    logic [DWIDTH-1:0] selA;
    logic [DWIDTH-1:0] selB;

    // Ready is held low while reset is asserted, even though state is IDLE.
    assign idle     = rst_n && (state_q == IDLE);
    assign reqValid = {bus.req1_valid, bus.req0_valid};

    rr_arbiter_2 uArb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (reqValid),
        .update_i (arbUpdate),
        .served_i (grantee_q),
        .grant_o  (grant)
    );

    assign reqReady  = idle ? grant : 2'b00;
    assign handshake = |(reqReady & reqValid);
    assign hsSel     = reqReady[1];
    assign selOp     = hsSel ? bus.req1_op : bus.req0_op;
    assign selA      = hsSel ? bus.req1_a  : bus.req0_a;
    assign selB      = hsSel ? bus.req1_b  : bus.req0_b;

    always_comb begin
        state_d   = state_q;
        grantee_d = grantee_q;
        aluOp_d   = aluOp_q;
        aluA_d    = aluA_q;
        aluB_d    = aluB_q;
        rspData_d = rspData_q;
        rspZero_d = rspZero_q;
        rspErr_d  = rspErr_q;
        arbUpdate = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    grantee_d = hsSel;
                    if (isLegalOp(selOp, LAST_OP)) begin
                        aluOp_d = selOp;
                        aluA_d  = selA;
                        aluB_d  = selB;
                        state_d = EXEC;
                    end else begin
                        rspData_d = '0;
                        rspZero_d = 1'b0;
                        rspErr_d  = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            EXEC:   state_d = WAIT_D;
            WAIT_D: state_d = CAPT;
            // alu_z trails alu_dout by a cycle and is low for a zero result.
            CAPT: begin
                rspData_d = alu_dout;
                rspZero_d = ~alu_z;
                rspErr_d  = 1'b0;
                state_d   = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    arbUpdate = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grantee_q <= 1'b0;
            aluOp_q   <= 4'b0000;
            aluA_q    <= '0;
            aluB_q    <= '0;
            rspData_q <= '0;
            rspZero_q <= 1'b0;
            rspErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grantee_q <= grantee_d;
            aluOp_q   <= aluOp_d;
            aluA_q    <= aluA_d;
            aluB_q    <= aluB_d;
            rspData_q <= rspData_d;
            rspZero_q <= rspZero_d;
            rspErr_q  <= rspErr_d;
        end
    end

    assign bus.req0_ready = reqReady[0];
    assign bus.req1_ready = reqReady[1];
    assign bus.rsp0_valid = (state_q == RESP) && !grantee_q;
    assign bus.rsp1_valid = (state_q == RESP) &&  grantee_q;
    assign bus.rsp_data   = rspData_q;
    assign bus.rsp_zero   = rspZero_q;
    assign bus.rsp_err    = rspErr_q;
    assign alu_operation  = aluOp_q;
    assign alu_operand1   = aluA_q;
    assign alu_operand2   = aluB_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios then random traffic,
// with a behavioural ALU stand-in on the alu_* ports.
module tb_alu_arbiter;

    import alu_pkg::*;

    localparam int DW = 16;

    typedef struct {
        int            who;
        logic [DW-1:0] data;
        logic          zero;
        logic          err;
        int            issueCycle;
        bit            seen;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstN;
    logic [DW-1:0] aluOperand1, aluOperand2, aluDout;
    logic [3:0]    aluOperation;
    logic          aluZ;
    logic          busy;

    alu_arbiter_if #(.DWIDTH(DW)) bus ();

    alu_arbiter #(.DWIDTH(DW), .LAST_OP(LAST_OP)) dut (
        .clk           (clk),
        .rst_n         (rstN),
        .bus           (bus),
        .alu_operand1  (aluOperand1),
        .alu_operand2  (aluOperand2),
        .alu_operation (aluOperation),
        .alu_dout      (aluDout),
        .alu_z         (aluZ),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // External ALU: result one cycle after its inputs, flag one cycle later.
    always @(posedge clk) begin
        case (aluOperation)
            PASS:    aluDout <= aluOperand1;
            ADD:     aluDout <= aluOperand1 + aluOperand2;
            SUB:     aluDout <= aluOperand1 - aluOperand2;
            SHL1:    aluDout <= aluOperand1 << 1;
            SHL2:    aluDout <= aluOperand1 << 2;
            SHR4:    aluDout <= aluOperand1 >> 4;
            INC:     aluDout <= aluOperand1 + 1'b1;
            default: aluDout <= '0;
        endcase
        aluZ <= (aluDout != '0);
    end

    int   vectors     = 0;
    int   miscompares = 0;
    int   cycleCnt    = 0;
    exp_t expQ[$];

    bit            pend[2];
    logic [3:0]    pOp[2];
    logic [DW-1:0] pA[2];
    logic [DW-1:0] pB[2];
    int            lastServedM = 1;
    logic [3:0]    mOp;
    logic [DW-1:0] mA, mB;
    int            rspReadyPct = 100;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Reference result from plain modular arithmetic on the opcode meaning.
    function automatic logic [DW-1:0] refResult(input logic [3:0] op, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        longint unsigned ua, ub, r, modulus;
        modulus = longint'(1) << DW;
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            PASS:    r = ua;
            ADD:     r = ua + ub;
            SUB:     r = ua + modulus - ub;
            SHL1:    r = ua * 2;
            SHL2:    r = ua * 4;
            SHR4:    r = ua / 16;
            INC:     r = ua + 1;
            default: r = 0;
        endcase
        return DW'(r % modulus);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cycleCnt);
        end
    endtask

    task automatic driveReq();
        bus.req0_valid = pend[0];
        bus.req0_op    = pOp[0];
        bus.req0_a     = pA[0];
        bus.req0_b     = pB[0];
        bus.req1_valid = pend[1];
        bus.req1_op    = pOp[1];
        bus.req1_a     = pA[1];
        bus.req1_b     = pB[1];
    endtask

    task automatic checkReset();
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_rsp_valid", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd0);
        checkOutput("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        checkOutput("rst_rsp_flags", 64'({bus.rsp_zero, bus.rsp_err}), 64'd0);
        checkOutput("rst_alu_op", 64'(aluOperation), 64'd0);
        checkOutput("rst_alu_operands", 64'({aluOperand1, aluOperand2}), 64'd0);
        checkOutput("rst_req_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
    endtask

    // One clock: check grant/ALU inputs at negedge, record handshakes, then update drive.
    task automatic tick();
        int         hs;
        logic [1:0] expMask;
        exp_t       e;
        @(negedge clk);
        hs = -1;
        if (busy) checkOutput("ready_while_busy", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
        checkOutput("alu_inputs", 64'({aluOperation, aluOperand1, aluOperand2}), 64'({mOp, mA, mB}));
        if (!busy && rstN && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) expMask = (lastServedM == 0) ? 2'b10 : 2'b01;
            else                    expMask = pend[0] ? 2'b01 : 2'b10;
            checkOutput("grant", 64'({bus.req1_ready, bus.req0_ready}), 64'(expMask));
        end
        if (bus.req0_ready && bus.req0_valid)      hs = 0;
        else if (bus.req1_ready && bus.req1_valid) hs = 1;
        if (hs >= 0) begin
            e.who        = hs;
            e.err        = (pOp[hs] > LAST_OP);
            e.data       = e.err ? '0 : refResult(pOp[hs], pA[hs], pB[hs]);
            e.zero       = !e.err && (e.data == '0);
            e.issueCycle = cycleCnt;
            e.seen       = 1'b0;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        if (hs >= 0) begin
            pend[hs] = 1'b0;
            if (!e.err) begin
                mOp = pOp[hs];
                mA  = pA[hs];
                mB  = pB[hs];
            end
        end
        bus.rsp_ready = ($urandom_range(0, 99) < rspReadyPct);
        driveReq();
    endtask

    task automatic drain(input int maxCycles);
        int n = 0;
        while ((pend[0] || pend[1] || expQ.size() != 0) && n < maxCycles) begin
            tick();
            n++;
        end
        if (n >= maxCycles) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: %0d requests pending, %0d responses outstanding after %0d cycles",
                     int'(pend[0]) + int'(pend[1]), expQ.size(), n);
        end
    endtask

    task automatic applyStimulus(input bit use0, input logic [3:0] op0, input logic [DW-1:0] a0,
                                 input logic [DW-1:0] b0, input bit use1, input logic [3:0] op1,
                                 input logic [DW-1:0] a1, input logic [DW-1:0] b1);
        if (use0) begin
            pend[0] = 1'b1; pOp[0] = op0; pA[0] = a0; pB[0] = b0;
        end
        if (use1) begin
            pend[1] = 1'b1; pOp[1] = op1; pA[1] = a1; pB[1] = b1;
        end
        driveReq();
        drain(200);
    endtask

    // Response monitor: compares every presented response with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstN !== 1'b1) continue;
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_rsp: got rsp valid %b%b, required none", bus.rsp1_valid,
                             bus.rsp0_valid);
                end else begin
                    e = expQ[0];
                    checkOutput("rsp_valid", 64'({bus.rsp1_valid, bus.rsp0_valid}),
                                (e.who == 1) ? 64'd2 : 64'd1);
                    checkOutput("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                    checkOutput("rsp_zero", 64'(bus.rsp_zero), 64'(e.zero));
                    checkOutput("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    if (!e.seen) begin
                        checkOutput("latency", 64'(cycleCnt - e.issueCycle), e.err ? 64'd1 : 64'd4);
                        expQ[0].seen = 1'b1;
                    end
                    if (bus.rsp_ready) begin
                        void'(expQ.pop_front());
                        lastServedM = e.who;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rstN = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        pOp[0] = '0; pOp[1] = '0; pA[0] = '0; pA[1] = '0; pB[0] = '0; pB[1] = '0;
        mOp = '0; mA = '0; mB = '0;
        driveReq();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkReset();
        driveReq();
        rstN = 1'b1;

        $display("[TB] directed: single, zero result, simultaneous, illegal op");
        applyStimulus(1, ADD, 16'd3, 16'd4, 0, '0, '0, '0);
        applyStimulus(0, '0, '0, '0, 1, SUB, 16'd5, 16'd5);
        applyStimulus(1, INC, 16'hFFFF, 16'h0000, 1, SHR4, 16'h1230, 16'h0000);
        applyStimulus(1, ADD, 16'h0010, 16'h0001, 1, SHL1, 16'h4001, 16'h0000);
        applyStimulus(1, 4'b1010, 16'h5555, 16'h1111, 0, '0, '0, '0);

        $display("[TB] directed: backpressure");
        rspReadyPct   = 0;
        bus.rsp_ready = 1'b0;
        pend[0] = 1'b1; pOp[0] = ADD; pA[0] = 16'h1234; pB[0] = 16'h0101;
        driveReq();
        n = 0;
        while (!(expQ.size() != 0 && expQ[0].seen) && n < 20) begin
            tick();
            n++;
        end
        repeat (5) tick();
        checkOutput("bp_hold", 64'({busy, bus.rsp0_valid}), 64'd3);
        rspReadyPct = 100;
        drain(20);
        tick();
        checkOutput("bp_release", 64'(busy), 64'd0);

        $display("[TB] directed: reset during WAIT_D");
        pend[1] = 1'b1; pOp[1] = ADD; pA[1] = 16'd9; pB[1] = 16'd9;
        driveReq();
        n = 0;
        while (pend[1] && n < 20) begin
            tick();
            n++;
        end
        tick();
        rstN = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        @(posedge clk);
        #1;
        checkReset();
        expQ.delete();
        lastServedM = 1;
        mOp = '0; mA = '0; mB = '0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        driveReq();
        rstN = 1'b1;
        repeat (2) tick();
        applyStimulus(0, '0, '0, '0, 1, ADD, 16'd9, 16'd9);

        $display("[TB] random traffic");
        rspReadyPct = 60;
        for (int c = 0; c < 800; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 3) == 0) begin
                    pend[r] = 1'b1;
                    pOp[r]  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
                    pA[r]   = DW'($urandom);
                    pB[r]   = ($urandom_range(0, 7) == 0) ? pA[r] : DW'($urandom);
                    if ($urandom_range(0, 7) == 0) pA[r] = DW'($urandom_range(0, 1)) ? 16'hFFFF : 16'h0000;
                end
            end
            driveReq();
            tick();
        end
        rspReadyPct = 100;
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
